// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types: stage depth selector, stage register payloads and their bubbles.
package pipe_stage_buf_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OCC_W      = 2;

  // Storage depth of a pipeline stage buffer.
  typedef enum int unsigned {
    PIPE_REG  = 1,
    PIPE_SKID = 2
  } pipe_depth_t;

  typedef enum logic [1:0] {
    NO_STORE   = 2'd0,
    STORE_BYTE = 2'd1,
    STORE_HALF = 2'd2,
    STORE_WORD = 2'd3
  } mem_store_type_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    TRAP   = 2'd3
  } control_type_t;

  // Decode-stage register payload.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       instr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  write_enable;
    mem_store_type_t       mem_store_type;
    control_type_t         control_type;
  } ID_regs_t;

  // Execute-stage register payload.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  write_enable;
    mem_store_type_t       mem_store_type;
    control_type_t         control_type;
  } EX_regs_t;

  // Bubbles are architecturally inert: no register write, no store, no redirect.
  localparam ID_regs_t ID_BUBBLE = '{
    pc:             '0,
    instr:          '0,
    rd:             '0,
    write_enable:   1'b0,
    mem_store_type: NO_STORE,
    control_type:   NORMAL
  };

  localparam EX_regs_t EX_BUBBLE = '{
    pc:             '0,
    alu_result:     '0,
    store_data:     '0,
    rd:             '0,
    write_enable:   1'b0,
    mem_store_type: NO_STORE,
    control_type:   NORMAL
  };

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module pipe_stage_buf_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  // Count up on inc, hold at all-ones, clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage: plain register (DEPTH=1) or skid buffer (DEPTH=2)
// with valid/ready handshake, stall, flush and a saturating stall-cycle counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned     WIDTH  = 64,
  parameter int unsigned     DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned     CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clear,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             blocked;

  // Reject unsupported depths at elaboration.
  if ((DEPTH != 32'(PIPE_REG)) && (DEPTH != 32'(PIPE_SKID))) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be 1 or 2");
  end

  assign not_empty = (occ_q != OCC_EMPTY);
  assign out_valid = not_empty & ~stall;
  assign out_data  = not_empty ? head_q : BUBBLE;
  assign occupancy = occ_q;

  // Ready: the plain register passes downstream ready through; the skid buffer does not.
  if (DEPTH == 32'(PIPE_REG)) begin : g_reg_ready
    assign in_ready = ~stall & (~not_empty | out_ready);
  end else begin : g_skid_ready
    assign in_ready = ~stall & (occ_q != OCC_TWO);
  end

  assign push    = in_valid & in_ready & ~flush;
  assign pop     = out_valid & out_ready;
  assign blocked = not_empty & (stall | ~out_ready);

  // Next-state: pop shifts the tail forward, push writes the first free slot after the pop.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      if (pop) begin
        head_d = tail_q;
        occ_d  = occ_d - 2'd1;
      end
      if (push) begin
        if (occ_d == OCC_EMPTY) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
        occ_d = occ_d + 2'd1;
      end
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q  <= OCC_EMPTY;
      head_q <= BUBBLE;
      tail_q <= BUBBLE;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  pipe_stage_buf_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (blocked),
    .value (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: instance a is a DEPTH=1 stage register, instance b a DEPTH=2 skid buffer.
module tb_pipe_stage_buf;

  localparam int unsigned W  = 64;
  localparam logic [W-1:0] B_BUBBLE = 64'hDEAD;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic         a_in_valid = 1'b0, a_out_ready = 1'b0, a_stall = 1'b0, a_flush = 1'b0, a_cnt_clear = 1'b0;
  logic [W-1:0] a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [1:0]   a_occupancy;
  logic [15:0]  a_stall_cycles;

  logic         b_in_valid = 1'b0, b_out_ready = 1'b0, b_stall = 1'b0, b_flush = 1'b0, b_cnt_clear = 1'b0;
  logic [W-1:0] b_in_data = '0;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occupancy;
  logic [15:0]  b_stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(1), .BUBBLE('0), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall(a_stall), .flush(a_flush), .cnt_clear(a_cnt_clear),
    .occupancy(a_occupancy), .stall_cycles(a_stall_cycles)
  );

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2), .BUBBLE(B_BUBBLE), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall(b_stall), .flush(b_flush), .cnt_clear(b_cnt_clear),
    .occupancy(b_occupancy), .stall_cycles(b_stall_cycles)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("a_rst_occ",   64'(a_occupancy), 64'd0);
    check("a_rst_valid", 64'(a_out_valid), 64'd0);
    check("a_rst_data",  a_out_data, 64'd0);
    check("a_rst_cnt",   64'(a_stall_cycles), 64'd0);
    check("a_rst_ready", 64'(a_in_ready), 64'd1);
    check("b_rst_ready", 64'(b_in_ready), 64'd1);
    check("b_rst_data",  b_out_data, B_BUBBLE);
    #11 reset = 1'b1;

    // 1: DEPTH=1 push 0xA5
    a_in_valid = 1'b1; a_in_data = 64'hA5; a_out_ready = 1'b1;
    #1 check("a_push_ready", 64'(a_in_ready), 64'd1);
    tick(1);
    a_in_valid = 1'b0;
    check("a_push_valid", 64'(a_out_valid), 64'd1);
    check("a_push_data",  a_out_data, 64'hA5);
    check("a_push_occ",   64'(a_occupancy), 64'd1);

    // 2: DEPTH=1 full, stall 3 cycles
    a_out_ready = 1'b0; a_stall = 1'b1;
    #1;
    check("a_stall_valid", 64'(a_out_valid), 64'd0);
    check("a_stall_ready", 64'(a_in_ready), 64'd0);
    tick(3);
    check("a_stall_occ",  64'(a_occupancy), 64'd1);
    check("a_stall_cnt",  64'(a_stall_cycles), 64'd3);
    a_stall = 1'b0;
    #1;
    check("a_release_valid", 64'(a_out_valid), 64'd1);
    check("a_release_data",  a_out_data, 64'hA5);
    check("a_full_noready",  64'(a_in_ready), 64'd0);

    // DEPTH=1 full + pop + push replaces head
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 64'hC3;
    #1 check("a_passthru_ready", 64'(a_in_ready), 64'd1);
    tick(1);
    a_in_valid = 1'b0;
    check("a_replace_data", a_out_data, 64'hC3);
    check("a_replace_occ",  64'(a_occupancy), 64'd1);
    check("a_replace_cnt",  64'(a_stall_cycles), 64'd3);

    // 5: saturation, then clear beats increment
    a_out_ready = 1'b0;
    tick(65540);
    check("a_sat_cnt", 64'(a_stall_cycles), 64'hFFFF);
    a_cnt_clear = 1'b1;
    tick(1);
    check("a_clear_cnt", 64'(a_stall_cycles), 64'd0);
    a_cnt_clear = 1'b0;
    tick(1);
    check("a_after_clear_cnt", 64'(a_stall_cycles), 64'd1);

    // Flush with stall: flush wins, push dropped
    a_stall = 1'b1; a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 64'h77;
    #1 check("a_flush_stall_ready", 64'(a_in_ready), 64'd0);
    tick(1);
    a_flush = 1'b0; a_stall = 1'b0; a_in_valid = 1'b0;
    check("a_flush_occ",  64'(a_occupancy), 64'd0);
    check("a_flush_data", a_out_data, 64'd0);

    // 3: DEPTH=2 fill with 0x11, 0x22 then drain in order
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h11;
    tick(1);
    check("b_fill1_occ",   64'(b_occupancy), 64'd1);
    check("b_fill1_ready", 64'(b_in_ready), 64'd1);
    check("b_fill1_data",  b_out_data, 64'h11);
    b_in_data = 64'h22;
    tick(1);
    b_in_valid = 1'b0;
    check("b_fill2_occ",   64'(b_occupancy), 64'd2);
    check("b_fill2_ready", 64'(b_in_ready), 64'd0);
    check("b_fill2_data",  b_out_data, 64'h11);
    b_out_ready = 1'b1;
    #1 check("b_full_ready_indep", 64'(b_in_ready), 64'd0);
    tick(1);
    check("b_pop1_data", b_out_data, 64'h22);
    check("b_pop1_occ",  64'(b_occupancy), 64'd1);
    tick(1);
    check("b_pop2_occ",   64'(b_occupancy), 64'd0);
    check("b_pop2_valid", 64'(b_out_valid), 64'd0);
    check("b_pop2_data",  b_out_data, B_BUBBLE);
    check("b_cnt",        64'(b_stall_cycles), 64'd1);

    // DEPTH=2 push and pop in the same cycle
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h44;
    tick(1);
    b_in_data = 64'h55; b_out_ready = 1'b1;
    tick(1);
    b_in_valid = 1'b0;
    check("b_pushpop_data", b_out_data, 64'h55);
    check("b_pushpop_occ",  64'(b_occupancy), 64'd1);

    // 4: flush with occupancy=1 and a concurrent push
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h33; b_flush = 1'b1;
    #1 check("b_flush_valid_ungated", 64'(b_out_valid), 64'd1);
    tick(1);
    b_flush = 1'b0; b_in_valid = 1'b0;
    check("b_flush_occ",  64'(b_occupancy), 64'd0);
    check("b_flush_data", b_out_data, B_BUBBLE);

    // 6: async reset with occupancy=2, then first push accepted
    b_in_valid = 1'b1; b_in_data = 64'h66;
    tick(1);
    b_in_data = 64'h77;
    tick(1);
    b_in_valid = 1'b0;
    check("b_pre_rst_occ", 64'(b_occupancy), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("b_async_occ",   64'(b_occupancy), 64'd0);
    check("b_async_valid", 64'(b_out_valid), 64'd0);
    check("b_async_data",  b_out_data, B_BUBBLE);
    check("b_async_ready", 64'(b_in_ready), 64'd1);
    check("b_async_cnt",   64'(b_stall_cycles), 64'd0);
    #1 reset = 1'b1;
    b_in_valid = 1'b1; b_in_data = 64'h88; b_out_ready = 1'b1;
    #1 check("b_post_rst_ready", 64'(b_in_ready), 64'd1);
    tick(1);
    b_in_valid = 1'b0;
    check("b_post_rst_data",  b_out_data, 64'h88);
    check("b_post_rst_occ",   64'(b_occupancy), 64'd1);
    check("b_post_rst_valid", 64'(b_out_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
